// File: rtl/hypervisor_ctrl.sv
// Hypervisor trap/register controller for the $D640-$D67F window.
// Optional trap counter on read index 0x3E: define HYPER_TRAP_COUNTER_EN.
module hypervisor_ctrl #(
    parameter int         REGS     = 64,
    parameter logic [5:0] EXIT_IDX = 6'h3F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hyper_cs,
    input  logic [7:0] hyper_addr,
    input  logic [7:0] hyper_io_data_i,
    output logic [7:0] hyper_data_o,
    input  logic       cpu_write,
    input  logic       ready,
    input  logic       hyper_mode,
    output logic       hyp,
    output logic       load_user_reg,
    output logic [7:0] user_mapper_reg
);

    logic [7:0] regfile [REGS];
    logic [5:0] idx;
    logic [5:0] trap_idx;
    logic       acc;
    logic       wr;
    logic       usr_wr;
    logic       exit_wr;
    logic       store;
    logic [7:0] rd_val;
    logic       unused_ok;

    assign idx       = hyper_addr[5:0];
    assign unused_ok = &{1'b0, hyper_addr[7:6]};
    assign acc       = hyper_cs & ready;
    assign wr        = acc & cpu_write;
    assign usr_wr    = wr & ~hyper_mode;
    assign exit_wr   = wr & hyper_mode & (idx == EXIT_IDX);
    assign store     = wr & ~exit_wr;

`ifdef HYPER_TRAP_COUNTER_EN
    logic [7:0] trap_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_cnt <= 8'h00;
        end else if (usr_wr) begin
            trap_cnt <= trap_cnt + 8'h01;
        end
    end

    always_comb begin
        rd_val = regfile[idx];
        if (idx == 6'h3F) begin
            rd_val = {hyper_mode, 1'b0, trap_idx};
        end else if (idx == 6'h3E) begin
            rd_val = trap_cnt;
        end
    end
`else
    always_comb begin
        rd_val = regfile[idx];
        if (idx == 6'h3F) begin
            rd_val = {hyper_mode, 1'b0, trap_idx};
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++) begin
                regfile[i] <= 8'h00;
            end
        end else if (store) begin
            regfile[idx] <= hyper_io_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hyper_data_o    <= 8'h00;
            user_mapper_reg <= 8'h00;
        end else if (acc) begin
            hyper_data_o    <= rd_val;
            user_mapper_reg <= rd_val;
        end
    end

    // A new request outranks the clearing rule of its own handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hyp           <= 1'b0;
            load_user_reg <= 1'b0;
            trap_idx      <= 6'd0;
        end else begin
            if (usr_wr) begin
                hyp      <= 1'b1;
                trap_idx <= idx;
            end else if (hyper_mode) begin
                hyp <= 1'b0;
            end
            if (exit_wr) begin
                load_user_reg <= 1'b1;
            end else if (!hyper_mode) begin
                load_user_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hypervisor_ctrl.sv
// Directed table-driven bench for hypervisor_ctrl.
// Hand-written sequences cover async reset and the trap counter.
module tb_hypervisor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       hyper_cs;
    logic [7:0] hyper_addr;
    logic [7:0] hyper_io_data_i;
    logic [7:0] hyper_data_o;
    logic       cpu_write;
    logic       ready;
    logic       hyper_mode;
    logic       hyp;
    logic       load_user_reg;
    logic [7:0] user_mapper_reg;

    int total = 0;
    int bad   = 0;

    hypervisor_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .hyper_cs        (hyper_cs),
        .hyper_addr      (hyper_addr),
        .hyper_io_data_i (hyper_io_data_i),
        .hyper_data_o    (hyper_data_o),
        .cpu_write       (cpu_write),
        .ready           (ready),
        .hyper_mode      (hyper_mode),
        .hyp             (hyp),
        .load_user_reg   (load_user_reg),
        .user_mapper_reg (user_mapper_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cs;
        logic [7:0] addr;
        logic [7:0] data;
        logic       we;
        logic       rdy;
        logic       hm;
        logic       e_hyp;
        logic       e_lur;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic cs, logic [7:0] addr, logic [7:0] data,
                                logic we, logic rdy, logic hm, logic e_hyp,
                                logic e_lur, logic [7:0] e_dout);
        vec_t v;
        v.cs = cs; v.addr = addr; v.data = data; v.we = we; v.rdy = rdy;
        v.hm = hm; v.e_hyp = e_hyp; v.e_lur = e_lur; v.e_dout = e_dout;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(logic cs, logic [7:0] addr, logic [7:0] data,
                         logic we, logic rdy, logic hm);
        hyper_cs = cs; hyper_addr = addr; hyper_io_data_i = data;
        cpu_write = we; ready = rdy; hyper_mode = hm;
    endtask

    task automatic step(logic cs, logic [7:0] addr, logic [7:0] data,
                        logic we, logic rdy, logic hm);
        drive(cs, addr, data, we, rdy, hm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        // cs addr data we rdy hm | hyp lur dout
        tbl.push_back(mk(1, 8'h10, 8'h00, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h05, 8'hA5, 1, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h05, 8'h00, 0, 1, 1, 0, 0, 8'hA5));
        tbl.push_back(mk(1, 8'h00, 8'h42, 1, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h3F, 8'h00, 0, 1, 1, 0, 0, 8'h80));
        tbl.push_back(mk(1, 8'h00, 8'h00, 0, 1, 1, 0, 0, 8'h42));
        tbl.push_back(mk(1, 8'h3F, 8'h77, 1, 1, 1, 0, 1, 8'h80));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 0, 1, 8'h80));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h80));
        tbl.push_back(mk(1, 8'h3F, 8'h00, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h07, 8'h99, 1, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h07, 8'h00, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h07, 8'h99, 1, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 8'h3F, 8'h00, 0, 1, 0, 1, 0, 8'h07));
        tbl.push_back(mk(1, 8'h07, 8'h00, 0, 1, 1, 0, 0, 8'h99));
        tbl.push_back(mk(1, 8'h02, 8'h11, 1, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 8'h03, 8'h22, 1, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 8'h3F, 8'h00, 0, 1, 0, 1, 0, 8'h03));
        tbl.push_back(mk(1, 8'h02, 8'h00, 0, 1, 1, 0, 0, 8'h11));
        tbl.push_back(mk(0, 8'h04, 8'h5C, 1, 1, 1, 0, 0, 8'h11));
        tbl.push_back(mk(1, 8'h04, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h03, 8'h00, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h03, 8'h00, 0, 1, 1, 0, 0, 8'h22));

        #12;
        chk("rst_hyp", {7'd0, hyp}, 8'h00);
        chk("rst_lur", {7'd0, load_user_reg}, 8'h00);
        chk("rst_dout", hyper_data_o, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].cs, tbl[i].addr, tbl[i].data,
                 tbl[i].we, tbl[i].rdy, tbl[i].hm);
            chk($sformatf("v%0d_hyp", i), {7'd0, hyp}, {7'd0, tbl[i].e_hyp});
            chk($sformatf("v%0d_lur", i), {7'd0, load_user_reg},
                {7'd0, tbl[i].e_lur});
            chk($sformatf("v%0d_dout", i), hyper_data_o, tbl[i].e_dout);
            chk($sformatf("v%0d_umr", i), user_mapper_reg, tbl[i].e_dout);
        end

        // Async reset mid-trap: regfile[2]=11 is read while trapping.
        step(1, 8'h02, 8'h66, 1, 1, 0);
        chk("mt_hyp_set", {7'd0, hyp}, 8'h01);
        chk("mt_dout", hyper_data_o, 8'h11);
        #3 reset = 1'b1;
        #1;
        chk("mt_hyp_rst", {7'd0, hyp}, 8'h00);
        chk("mt_dout_rst", hyper_data_o, 8'h00);
        chk("mt_umr_rst", user_mapper_reg, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        step(1, 8'h10, 8'h00, 0, 1, 1);
        chk("post_rst_10", hyper_data_o, 8'h00);
        step(1, 8'h02, 8'h00, 0, 1, 1);
        chk("post_rst_02", hyper_data_o, 8'h00);

        // Async reset mid-exit.
        step(1, 8'h3F, 8'hEE, 1, 1, 1);
        chk("me_lur_set", {7'd0, load_user_reg}, 8'h01);
        #3 reset = 1'b1;
        #1;
        chk("me_lur_rst", {7'd0, load_user_reg}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

`ifdef HYPER_TRAP_COUNTER_EN
        for (int k = 0; k < 3; k++) begin
            step(1, 8'h08, 8'(k), 1, 1, 0);
        end
        step(0, 8'h00, 8'h00, 0, 1, 1);
        step(1, 8'h3E, 8'h00, 0, 1, 1);
        chk("cnt_3", hyper_data_o, 8'h03);
        step(1, 8'h3E, 8'hC3, 1, 1, 1);
        step(1, 8'h3E, 8'h00, 0, 1, 1);
        chk("cnt_hv_wr", hyper_data_o, 8'h03);
        for (int k = 0; k < 253; k++) begin
            step(1, 8'h09, 8'h01, 1, 1, 0);
        end
        step(1, 8'h3E, 8'h00, 0, 1, 1);
        chk("cnt_wrap", hyper_data_o, 8'h00);
`else
        step(1, 8'h3E, 8'h5A, 1, 1, 1);
        step(1, 8'h3E, 8'h00, 0, 1, 1);
        chk("reg_3e", hyper_data_o, 8'h5A);
        step(1, 8'h3E, 8'hC3, 1, 1, 0);
        step(1, 8'h3E, 8'h00, 0, 1, 1);
        chk("reg_3e_usr", hyper_data_o, 8'hC3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
